// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sprite DMA sequencer. A CPU write of page P to DMA_REG_ADDR
// stalls the CPU and copies $P00-$PFF to OAM_DATA_ADDR one byte at a time.
// This is done as alternating READ and WRITE bus cycles.
// Optional build macro: OAM_DMA_ALIGN_EN. When it is defined, an ALIGN cycle
// is inserted so that the first READ always lands on an even (parity==0) cycle.
//
// Bus ownership handshake: cpu_enable=0 means "CPU stalled, DMA owns the bus",
// and dma_active is always its exact complement. The bus mux must select the
// dma_* signals whenever dma_active=1. dma_done pulses in the first cycle
// after ownership has returned to the CPU.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_rw_n,
  input  logic [7:0]  bus_rd_data,
  output logic        cpu_enable,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_rw_n,
  output logic [7:0]  dma_data_out,
  output logic        dma_done,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  data_q;
  logic        done_q;
  logic        trigger;
  logic        last_byte;

  // A write to the DMA register is only honoured while the CPU is running.
  assign trigger   = (state == S_IDLE) && cpu_enable && !cpu_rw_n &&
                     (cpu_addr == DMA_REG_ADDR);
  assign last_byte = (idx == 8'hFF);

`ifdef OAM_DMA_ALIGN_EN
  logic parity;

  // Free-running cycle parity used to align the first READ to an even cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity <= 1'b0;
    else       parity <= ~parity;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (trigger) state_nxt = S_HALT;
`ifdef OAM_DMA_ALIGN_EN
      S_HALT:  state_nxt = parity ? S_READ : S_ALIGN;
`else
      S_HALT:  state_nxt = S_READ;
`endif
      S_ALIGN: state_nxt = S_READ;
      S_READ:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = last_byte ? S_IDLE : S_READ;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: page/index tracking, read-data latch and completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      page   <= 8'h00;
      idx    <= 8'h00;
      data_q <= 8'h00;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == S_WRITE) && last_byte;
      if (trigger) begin
        page <= cpu_data_out;
        idx  <= 8'h00;
      end
      if (state == S_READ)  data_q <= bus_rd_data;
      // The increment after the final byte wraps to 0 and is never used.
      if (state == S_WRITE) idx <= idx + 8'd1;
    end
  end

  // Output decode from the current state.
  always_comb begin
    cpu_enable = 1'b1;
    dma_addr   = 16'h0000;
    dma_rw_n   = 1'b1;
    case (state)
      S_HALT, S_ALIGN: cpu_enable = 1'b0;
      S_READ: begin
        cpu_enable = 1'b0;
        dma_addr   = {page, idx};
      end
      S_WRITE: begin
        cpu_enable = 1'b0;
        dma_addr   = OAM_DATA_ADDR;
        dma_rw_n   = 1'b0;
      end
      default: cpu_enable = 1'b1;
    endcase
    dma_active = ~cpu_enable;
  end

  assign dma_data_out = data_q;
  assign dma_done     = done_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: randomized bench for oam_dma_ctrl. A 64 KiB memory model
// answers bus_rd_data, and each transfer's expected bus activity is built as
// a per-cycle queue from the transfer rules. Build with +define+OAM_DMA_ALIGN_EN
// to check the aligned variant.
module tb_oam_dma_ctrl;

  logic        clk;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_rw_n;
  logic [7:0]  bus_rd_data;
  logic        cpu_enable;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_rw_n;
  logic [7:0]  dma_data_out;
  logic        dma_done;
  logic [2:0]  dbg_state;

  logic [7:0]  mem [65536];
  logic [7:0]  last_byte;
  int          edges;
  int          vectors;
  int          errors;

  oam_dma_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_data_out (cpu_data_out),
    .cpu_rw_n     (cpu_rw_n),
    .bus_rd_data  (bus_rd_data),
    .cpu_enable   (cpu_enable),
    .dma_active   (dma_active),
    .dma_addr     (dma_addr),
    .dma_rw_n     (dma_rw_n),
    .dma_data_out (dma_data_out),
    .dma_done     (dma_done),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges seen since reset release; bit 0 is the cycle parity.
  always @(posedge clk or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  assign bus_rd_data = mem[dma_addr];

  // ---------------- helpers ----------------
  function automatic logic [27:0] pack(input logic en, input logic act,
                                       input logic rw, input logic [15:0] a,
                                       input logic [7:0] d, input logic dn);
    return {en, act, rw, a, d, dn};
  endfunction

  function automatic logic [27:0] observed();
    return {cpu_enable, dma_active, dma_rw_n, dma_addr, dma_data_out, dma_done};
  endfunction

  task automatic check(input string tag, input logic [27:0] obs,
                       input logic [27:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    cpu_addr     = 16'($urandom);
    cpu_rw_n     = 1'b1;
    cpu_data_out = 8'($urandom);
  endtask

  task automatic apply_trigger(input logic [7:0] p);
    cpu_addr     = 16'h4014;
    cpu_rw_n     = 1'b0;
    cpu_data_out = p;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive_idle();
      @(negedge clk);
      check("idle", observed(), pack(1'b1, 1'b0, 1'b1, 16'h0, last_byte, 1'b0));
    end
  endtask

  // Wait so that the cycle right after the trigger edge has parity want_par.
  task automatic align_and_trigger(input logic [7:0] p, input logic want_par);
    if (1'(edges + 1) != want_par) idle_cycles(1);
    apply_trigger(p);
  endtask

  // Called with trigger inputs applied at a negedge. Checks every cycle of the
  // transfer against the expected queue. Optionally chains a new trigger in the
  // done cycle, or resets during the WRITE of byte abort_idx.
  task automatic do_dma(input logic [7:0] p, input bit chain,
                        input logic [7:0] next_p, input int abort_idx);
    logic [27:0] exp_q[$];
    logic [7:0]  lb;
    int          d;
    int          stalled;
    int          abort_pos;
    @(negedge clk);
`ifdef OAM_DMA_ALIGN_EN
    d = edges[0] ? 1 : 2;
`else
    d = 1;
`endif
    lb = last_byte;
    for (int i = 0; i < d; i++)
      exp_q.push_back(pack(1'b0, 1'b1, 1'b1, 16'h0, lb, 1'b0));
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(pack(1'b0, 1'b1, 1'b1, {p, 8'(i)}, lb, 1'b0));
      lb = mem[{p, 8'(i)}];
      exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 16'h2004, lb, 1'b0));
    end
    exp_q.push_back(pack(1'b1, 1'b0, 1'b1, 16'h0, lb, 1'b1));
    abort_pos = (abort_idx < 0) ? -1 : d + 2 * abort_idx + 1;
    stalled = 0;
    for (int pos = 0; pos < exp_q.size(); pos++) begin
      if (!cpu_enable) stalled++;
      check("dma_cycle", observed(), exp_q[pos]);
      if (pos == abort_pos) begin
        reset = 1'b1;
        #1;
        check("reset_now", observed(), pack(1'b1, 1'b0, 1'b1, 16'h0, 8'h00, 1'b0));
        last_byte = 8'h00;
        @(negedge clk);
        check("reset_hold", observed(), pack(1'b1, 1'b0, 1'b1, 16'h0, 8'h00, 1'b0));
        reset = 1'b0;
        drive_idle();
        return;
      end
      if (pos != exp_q.size() - 1) begin
        // The stalled CPU bus is driven with noise, including $4014 writes.
        cpu_addr     = ($urandom_range(0, 3) == 0) ? 16'h4014 : 16'($urandom);
        cpu_rw_n     = 1'($urandom);
        cpu_data_out = 8'($urandom);
        @(negedge clk);
      end
    end
    check("stall_len", 28'(stalled), 28'(d + 512));
    last_byte = lb;
    if (chain) begin
      apply_trigger(next_p);
    end else begin
      drive_idle();
      @(negedge clk);
      check("after_done", observed(), pack(1'b1, 1'b0, 1'b1, 16'h0, last_byte, 1'b0));
    end
  endtask

  task automatic non_trigger(input logic [15:0] a, input logic rw);
    cpu_addr     = a;
    cpu_rw_n     = rw;
    cpu_data_out = 8'($urandom);
    @(negedge clk);
    check("no_trigger", observed(), pack(1'b1, 1'b0, 1'b1, 16'h0, last_byte, 1'b0));
    idle_cycles(2);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] p;
    vectors   = 0;
    errors    = 0;
    last_byte = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

    reset = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    check("reset_state", observed(), pack(1'b1, 1'b0, 1'b1, 16'h0, 8'h00, 1'b0));
    reset = 1'b0;
    idle_cycles(3);

    // Reads of $4014 and writes elsewhere never start a transfer.
    non_trigger(16'h4014, 1'b1);
    non_trigger(16'h4015, 1'b0);
    non_trigger(16'h2014, 1'b0);

    // Page $02 with the known pattern.
    apply_trigger(8'h02);
    do_dma(8'h02, 1'b0, 8'h00, -1);
    idle_cycles($urandom_range(1, 4));

    // Trigger at both cycle parities.
    p = 8'($urandom);
    align_and_trigger(p, 1'b0);
    do_dma(p, 1'b0, 8'h00, -1);
    p = 8'($urandom);
    align_and_trigger(p, 1'b1);
    do_dma(p, 1'b0, 8'h00, -1);

    // Top page: addresses end at $FFFF without carrying into $0000.
    idle_cycles(2);
    apply_trigger(8'hFF);
    do_dma(8'hFF, 1'b0, 8'h00, -1);

    // Trigger in the done cycle starts the next transfer immediately.
    apply_trigger(8'h10);
    do_dma(8'h10, 1'b1, 8'h33, -1);
    do_dma(8'h33, 1'b0, 8'h00, -1);

    // Reset during the WRITE of byte $40, then a clean restart.
    p = 8'($urandom);
    apply_trigger(p);
    do_dma(p, 1'b0, 8'h00, 8'h40);
    idle_cycles(3);
    apply_trigger(8'h02);
    do_dma(8'h02, 1'b0, 8'h00, -1);

    // A couple of random pages with random gaps.
    for (int k = 0; k < 2; k++) begin
      idle_cycles($urandom_range(0, 5));
      p = 8'($urandom);
      apply_trigger(p);
      do_dma(p, 1'b0, 8'h00, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
